// File: rtl/mac_accumulator_pkg.sv
// mac_accumulator_pkg: shared state encoding and datapath widths for the MAC accumulator
package mac_accumulator_pkg;
  localparam int OPW   = 4;
  localparam int PRODW = 8;
  localparam int ACCW  = 12;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_accumulator_mult.sv
// parallelmultiplier: combinational 4x4 unsigned array multiplier built from shifted partial products
module parallelmultiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] o
);
  logic [7:0] pp [4];
  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = b[i] ? ({4'b0, a} << i) : 8'd0;
  end
  assign o = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums len products of operand pairs through a two-stage multiply/accumulate pipeline
module mac_accumulator
  import mac_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] acc_out,
  output logic        busy
);
  state_t state_q, state_d;
  logic [OPW-1:0] cnt_q, cnt_d, s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, xfer;
  logic [PRODW-1:0] s2_p_q, s2_p_d, prod;
  logic [ACCW-1:0] acc_q, acc_d;

  parallelmultiplier u_mult (.a(s1_a_q), .b(s1_b_q), .o(prod));

  assign in_ready  = state_q == RUN && cnt_q != '0;
  assign xfer      = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign acc_out   = acc_q;

  // next-state, remaining count, pipeline stages and accumulator update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_v_d  = xfer;
    s1_a_d  = xfer ? in_a : s1_a_q;
    s1_b_d  = xfer ? in_b : s1_b_q;
    s2_v_d  = s1_v_q;
    s2_p_d  = s1_v_q ? prod : s2_p_q;
    acc_d   = s2_v_q ? acc_q + ACCW'(s2_p_q) : acc_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d   = len;
        acc_d   = '0;
        state_d = len == '0 ? DONE : RUN;
      end
      RUN: if (xfer) begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? DRAIN : RUN;
      end
      DRAIN: state_d = !s1_v_q && !s2_v_q ? DONE : DRAIN;
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_p_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s2_v_q  <= s2_v_d;
      s2_p_q  <= s2_p_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scenarios with a result scoreboard checked by an independent monitor
module tb_mac_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] len = '0, in_a = '0, in_b = '0;
  logic in_ready, out_valid, busy;
  logic [11:0] acc_out;
  int checks = 0, errors = 0;
  int sb[$];
  logic [3:0] va[16], vb[16];

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted result is matched against the oldest expected sum
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %0d expected none", acc_out);
      end else chk("result", acc_out, sb.pop_front());
    end
  end

  task automatic run(input int n, input int gap, input int hold, input int exp);
    int t;
    sb.push_back(exp);
    start = 1'b1;
    len = 4'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      chk("in_ready_timeout", t, 0);
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      step();
      in_valid = 1'b0;
      if (i < n - 1)
        for (int g = 0; g < gap; g++) step();
    end
    if (n > 0) begin
      chk("no_ready_in_drain", in_ready, 0);
      for (int c = 0; c < 2; c++) begin
        chk("out_valid_early", out_valid, 0);
        step();
      end
      chk("out_valid_pre", out_valid, 0);
      step();
    end
    chk("out_valid_rise", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      start = h == 0;
      len = 4'd7;
      chk("held_acc", acc_out, exp);
      chk("held_valid", out_valid, 1);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_acc", acc_out, exp);
  endtask

  initial begin
    step();
    chk("rst_acc", acc_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    va[0] = 4'd3;  vb[0] = 4'd5;
    va[1] = 4'd15; vb[1] = 4'd15;
    va[2] = 4'd2;  vb[2] = 4'd7;
    run(3, 0, 0, 254);
    for (int i = 0; i < 15; i++) begin
      va[i] = 4'd15;
      vb[i] = 4'd15;
    end
    run(15, 0, 0, 3375);
    run(0, 0, 0, 0);
    va[0] = 4'd4; vb[0] = 4'd4;
    va[1] = 4'd9; vb[1] = 4'd3;
    run(2, 2, 5, 43);
    start = 1'b1;
    len = 4'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 4'd5;
      in_b = 4'd5;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_ready", in_ready, 0);
    chk("post_rst_busy", busy, 0);
    in_valid = 1'b0;
    va[0] = 4'd6; vb[0] = 4'd7;
    run(1, 0, 0, 42);
    step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
